// File: rtl/mem_top.sv
// MEM pipeline stage: issues word loads/stores on the CPU bus handshake, flags
// misaligned accesses and produces the MEM/WB register plus the ID forwarding value.
module mem_top #(
    parameter int          DATA_W         = 32,
    parameter int          ADDR_W         = 30,
    parameter logic [2:0]  EXP_MISS_ALIGN = 3'd4
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              stall,
    input  logic              flush,
    input  logic              int_detect,
    input  logic [ADDR_W-1:0] ex_pc,
    input  logic              ex_en,
    input  logic              ex_br_flag,
    input  logic [1:0]        ex_mem_op,
    input  logic [DATA_W-1:0] ex_mem_wr_data,
    input  logic [1:0]        ex_ctrl_op,
    input  logic [4:0]        ex_dst_addr,
    input  logic              ex_gpr_we_,
    input  logic [2:0]        ex_exp_code,
    input  logic [DATA_W-1:0] ex_out,
    output logic              bus_as_,
    output logic              bus_rw,
    output logic [ADDR_W-1:0] bus_addr,
    output logic [DATA_W-1:0] bus_wr_data,
    input  logic [DATA_W-1:0] bus_rd_data,
    input  logic              bus_rdy_,
    output logic              busy,
    output logic [DATA_W-1:0] fwd_data,
    output logic [ADDR_W-1:0] mem_pc,
    output logic              mem_en,
    output logic              mem_br_flag,
    output logic [1:0]        mem_ctrl_op,
    output logic [4:0]        mem_dst_addr,
    output logic              mem_gpr_we_,
    output logic [2:0]        mem_exp_code,
    output logic [DATA_W-1:0] mem_out
);

    localparam logic [1:0] OP_LDW = 2'b01;
    localparam logic [1:0] OP_STW = 2'b10;

    typedef enum logic [1:0] {IDLE, ACCESS, HOLD} state_t;

    state_t            state_q, state_d;
    logic [DATA_W-1:0] rd_buf_q, rd_buf_d;

    logic              is_ldw, is_stw, miss_align, acc, kill, done;
    logic [DATA_W-1:0] load_data, result;
    logic [2:0]        exp_code;
    logic              gpr_we_;

    logic [ADDR_W-1:0] mem_pc_q, mem_pc_d;
    logic              mem_en_q, mem_en_d;
    logic              mem_br_flag_q, mem_br_flag_d;
    logic [1:0]        mem_ctrl_op_q, mem_ctrl_op_d;
    logic [4:0]        mem_dst_addr_q, mem_dst_addr_d;
    logic              mem_gpr_we_q, mem_gpr_we_d;
    logic [2:0]        mem_exp_code_q, mem_exp_code_d;
    logic [DATA_W-1:0] mem_out_q, mem_out_d;

    assign is_ldw      = (ex_mem_op == OP_LDW);
    assign is_stw      = (ex_mem_op == OP_STW);
    assign miss_align  = ex_en & (is_ldw | is_stw) & (ex_out[1:0] != 2'b00);
    assign acc         = ex_en & (is_ldw | is_stw) & (ex_exp_code == 3'd0) & (ex_out[1:0] == 2'b00);
    assign kill        = flush | int_detect;
    assign bus_addr    = ex_out[ADDR_W+1:2];
    assign bus_wr_data = ex_mem_wr_data;
    assign bus_rw      = reset | ~is_stw;

    // Bus handshake: a strobe in IDLE is combinational so zero-wait slaves finish in one cycle.
    always_comb begin
        state_d  = state_q;
        rd_buf_d = rd_buf_q;
        bus_as_  = 1'b1;
        busy     = 1'b0;
        done     = 1'b0;
        case (state_q)
            IDLE: begin
                if (acc && !kill) begin
                    bus_as_ = 1'b0;
                    if (!bus_rdy_) begin
                        done = 1'b1;
                        if (stall) state_d = HOLD;
                    end else begin
                        busy    = 1'b1;
                        state_d = ACCESS;
                    end
                end
            end
            ACCESS: begin
                // A flush here cannot abort the slave; the cycle runs out and the MEM/WB bubble drops it.
                bus_as_ = 1'b0;
                if (!bus_rdy_) begin
                    done    = 1'b1;
                    state_d = stall ? HOLD : IDLE;
                end else begin
                    busy = 1'b1;
                end
            end
            HOLD: begin
                if (!stall) state_d = IDLE;
            end
            default: state_d = IDLE;
        endcase
        if (done) rd_buf_d = bus_rd_data;
        if (reset) begin
            bus_as_ = 1'b1;
            busy    = 1'b0;
        end
    end

    // HOLD replays the buffered word so a stalled load is never re-issued on the bus.
    always_comb begin
        load_data = (state_q == HOLD) ? rd_buf_q : bus_rd_data;
        if (miss_align)  result = '0;
        else if (is_ldw) result = load_data;
        else if (is_stw) result = '0;
        else             result = ex_out;
        exp_code = miss_align ? EXP_MISS_ALIGN : ex_exp_code;
        gpr_we_  = (miss_align | is_stw) ? 1'b1 : ex_gpr_we_;
    end

    assign fwd_data = result;

    always_comb begin
        mem_pc_d       = mem_pc_q;
        mem_en_d       = mem_en_q;
        mem_br_flag_d  = mem_br_flag_q;
        mem_ctrl_op_d  = mem_ctrl_op_q;
        mem_dst_addr_d = mem_dst_addr_q;
        mem_gpr_we_d   = mem_gpr_we_q;
        mem_exp_code_d = mem_exp_code_q;
        mem_out_d      = mem_out_q;
        if (!(stall | busy)) begin
            if (kill) begin
                mem_pc_d       = '0;
                mem_en_d       = 1'b0;
                mem_br_flag_d  = 1'b0;
                mem_ctrl_op_d  = '0;
                mem_dst_addr_d = '0;
                mem_gpr_we_d   = 1'b1;
                mem_exp_code_d = '0;
                mem_out_d      = '0;
            end else begin
                mem_pc_d       = ex_pc;
                mem_en_d       = ex_en;
                mem_br_flag_d  = ex_br_flag;
                mem_ctrl_op_d  = ex_ctrl_op;
                mem_dst_addr_d = ex_dst_addr;
                mem_gpr_we_d   = gpr_we_;
                mem_exp_code_d = exp_code;
                mem_out_d      = result;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q        <= IDLE;
            mem_pc_q       <= '0;
            mem_en_q       <= 1'b0;
            mem_br_flag_q  <= 1'b0;
            mem_ctrl_op_q  <= '0;
            mem_dst_addr_q <= '0;
            mem_gpr_we_q   <= 1'b1;
            mem_exp_code_q <= '0;
            mem_out_q      <= '0;
        end else begin
            state_q        <= state_d;
            mem_pc_q       <= mem_pc_d;
            mem_en_q       <= mem_en_d;
            mem_br_flag_q  <= mem_br_flag_d;
            mem_ctrl_op_q  <= mem_ctrl_op_d;
            mem_dst_addr_q <= mem_dst_addr_d;
            mem_gpr_we_q   <= mem_gpr_we_d;
            mem_exp_code_q <= mem_exp_code_d;
            mem_out_q      <= mem_out_d;
        end
    end

    always_ff @(posedge clk) begin
        rd_buf_q <= rd_buf_d;
    end

    assign mem_pc       = mem_pc_q;
    assign mem_en       = mem_en_q;
    assign mem_br_flag  = mem_br_flag_q;
    assign mem_ctrl_op  = mem_ctrl_op_q;
    assign mem_dst_addr = mem_dst_addr_q;
    assign mem_gpr_we_  = mem_gpr_we_q;
    assign mem_exp_code = mem_exp_code_q;
    assign mem_out      = mem_out_q;

endmodule

// File: tb/tb_mem_top.sv
// Bench for mem_top: fixed vectors, hand-written stall/flush/reset sequences and
// random instructions compared with a transaction-level model of the MEM stage.
module tb_mem_top;

    logic        clk = 1'b0;
    logic        reset, stall, flush, int_detect;
    logic [29:0] ex_pc;
    logic        ex_en, ex_br_flag;
    logic [1:0]  ex_mem_op, ex_ctrl_op;
    logic [31:0] ex_mem_wr_data, ex_out;
    logic [4:0]  ex_dst_addr;
    logic        ex_gpr_we_;
    logic [2:0]  ex_exp_code;
    logic        bus_as_, bus_rw, bus_rdy_, busy;
    logic [29:0] bus_addr;
    logic [31:0] bus_wr_data, bus_rd_data, fwd_data;
    logic [29:0] mem_pc;
    logic        mem_en, mem_br_flag, mem_gpr_we_;
    logic [1:0]  mem_ctrl_op;
    logic [4:0]  mem_dst_addr;
    logic [2:0]  mem_exp_code;
    logic [31:0] mem_out;

    int total = 0;
    int bad   = 0;

    logic [29:0] last_addr;
    logic        last_rw;
    logic [31:0] last_wd;

    always #5 clk = ~clk;

    mem_top dut (
        .clk(clk), .reset(reset), .stall(stall), .flush(flush), .int_detect(int_detect),
        .ex_pc(ex_pc), .ex_en(ex_en), .ex_br_flag(ex_br_flag), .ex_mem_op(ex_mem_op),
        .ex_mem_wr_data(ex_mem_wr_data), .ex_ctrl_op(ex_ctrl_op), .ex_dst_addr(ex_dst_addr),
        .ex_gpr_we_(ex_gpr_we_), .ex_exp_code(ex_exp_code), .ex_out(ex_out),
        .bus_as_(bus_as_), .bus_rw(bus_rw), .bus_addr(bus_addr), .bus_wr_data(bus_wr_data),
        .bus_rd_data(bus_rd_data), .bus_rdy_(bus_rdy_), .busy(busy), .fwd_data(fwd_data),
        .mem_pc(mem_pc), .mem_en(mem_en), .mem_br_flag(mem_br_flag), .mem_ctrl_op(mem_ctrl_op),
        .mem_dst_addr(mem_dst_addr), .mem_gpr_we_(mem_gpr_we_), .mem_exp_code(mem_exp_code),
        .mem_out(mem_out)
    );

    typedef struct {
        logic [1:0]  op;
        logic [31:0] out;
        logic [31:0] wr;
        logic [2:0]  ec;
        logic        we_;
        int          waits;
        logic [31:0] rdata;
        logic [31:0] e_out;
        logic        e_we_;
        logic [2:0]  e_ec;
        int          e_strobes;
        int          e_busy;
        logic [29:0] e_addr;
        logic        e_rw;
    } vec_t;

    typedef struct {
        logic [31:0] out;
        logic        we_;
        logic [2:0]  ec;
        int          strobes;
    } exp_t;

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] req);
        total++;
        if (act !== req) begin
            bad++;
            $display("FAIL %s actual=%h required=%h", nm, act, req);
        end
    endtask

    // Expected outcome of one instruction, straight from the stage's rules.
    function automatic exp_t model(input logic [1:0] op, input logic [31:0] out,
                                   input logic [2:0] ec, input logic we_,
                                   input logic [31:0] rdata, input int waits);
        exp_t r;
        bit is_mem, mis;
        is_mem = (op == 2'd1) || (op == 2'd2);
        mis    = is_mem && (out % 4 != 0);
        r.ec   = mis ? 3'd4 : ec;
        r.we_  = (mis || op == 2'd2) ? 1'b1 : we_;
        if (mis)             r.out = 32'd0;
        else if (op == 2'd1) r.out = rdata;
        else if (op == 2'd2) r.out = 32'd0;
        else                 r.out = out;
        r.strobes = (is_mem && !mis && ec == 3'd0) ? waits + 1 : 0;
        return r;
    endfunction

    // Drives one EX entry, acts as a slave with 'waits' wait states, and returns
    // once the MEM/WB register has taken the instruction.
    task automatic run_instr(input logic [1:0] op, input logic [31:0] out, input logic [31:0] wr,
                             input logic [2:0] ec, input logic we_, input logic [4:0] dst,
                             input logic [29:0] pc, input int waits, input logic [31:0] rdata,
                             input int kill_at, output int strobes, output int busys,
                             output logic [31:0] fwd_seen);
        bit done = 0;
        ex_en = 1'b1; ex_mem_op = op; ex_out = out; ex_mem_wr_data = wr; ex_exp_code = ec;
        ex_gpr_we_ = we_; ex_dst_addr = dst; ex_pc = pc; ex_ctrl_op = 2'd1; ex_br_flag = 1'b0;
        bus_rdy_ = 1'b1;
        strobes = 0; busys = 0; fwd_seen = '0;
        for (int c = 0; c < 20 && !done; c++) begin
            if (c == kill_at) int_detect = 1'b1;
            #1;
            if (bus_as_ === 1'b0) begin
                strobes++;
                last_addr = bus_addr; last_rw = bus_rw; last_wd = bus_wr_data;
                if (strobes - 1 >= waits) begin
                    bus_rdy_ = 1'b0;
                    bus_rd_data = rdata;
                end
            end
            #1;
            if (busy === 1'b1) busys++;
            else begin
                done = 1;
                fwd_seen = fwd_data;
            end
            @(posedge clk); #1;
            bus_rdy_ = 1'b1;
        end
        if (!done) chk("access_timeout", 32'd0, 32'd1);
        int_detect = 1'b0;
        ex_en = 1'b0; ex_mem_op = 2'd0;
    endtask

    initial begin
        #400000;
        $display("FAIL watchdog actual=timeout required=finish");
        $fatal(1, "watchdog");
    end

    initial begin
        vec_t vecs[8];
        int s, b, extra;
        logic [31:0] fw;
        exp_t e;

        vecs[0] = '{2'd1, 32'h0000_0100, 32'h0,         3'd0, 1'b0, 2, 32'hDEAD_BEEF, 32'hDEAD_BEEF, 1'b0, 3'd0, 3, 2, 30'h40,       1'b1};
        vecs[1] = '{2'd2, 32'h0000_0008, 32'h1234_5678, 3'd0, 1'b0, 0, 32'h0,         32'h0,         1'b1, 3'd0, 1, 0, 30'h2,        1'b0};
        vecs[2] = '{2'd1, 32'h0000_0102, 32'h0,         3'd0, 1'b0, 0, 32'h0,         32'h0,         1'b1, 3'd4, 0, 0, 30'h0,        1'b1};
        vecs[3] = '{2'd0, 32'h0000_0055, 32'h0,         3'd0, 1'b0, 0, 32'h0,         32'h55,        1'b0, 3'd0, 0, 0, 30'h0,        1'b1};
        vecs[4] = '{2'd2, 32'h0000_0007, 32'hFFFF_0000, 3'd0, 1'b0, 0, 32'h0,         32'h0,         1'b1, 3'd4, 0, 0, 30'h0,        1'b0};
        vecs[5] = '{2'd3, 32'h0000_0033, 32'h0,         3'd0, 1'b0, 0, 32'h0,         32'h33,        1'b0, 3'd0, 0, 0, 30'h0,        1'b1};
        vecs[6] = '{2'd1, 32'hFFFF_FFFC, 32'h0,         3'd0, 1'b0, 1, 32'hA5A5_5A5A, 32'hA5A5_5A5A, 1'b0, 3'd0, 2, 1, 30'h3FFF_FFFF, 1'b1};
        vecs[7] = '{2'd2, 32'h0000_0010, 32'h0,         3'd3, 1'b0, 0, 32'h0,         32'h0,         1'b1, 3'd3, 0, 0, 30'h0,        1'b0};

        reset = 1'b1; stall = 1'b0; flush = 1'b0; int_detect = 1'b0;
        ex_pc = '0; ex_en = 1'b0; ex_br_flag = 1'b0; ex_mem_op = '0; ex_ctrl_op = '0;
        ex_mem_wr_data = '0; ex_out = '0; ex_dst_addr = '0; ex_gpr_we_ = 1'b1; ex_exp_code = '0;
        bus_rd_data = '0; bus_rdy_ = 1'b1;
        repeat (2) @(posedge clk);
        #1;
        chk("rst_bus_as_", {31'd0, bus_as_}, 32'd1);
        chk("rst_bus_rw", {31'd0, bus_rw}, 32'd1);
        chk("rst_busy", {31'd0, busy}, 32'd0);
        chk("rst_mem_en", {31'd0, mem_en}, 32'd0);
        chk("rst_mem_gpr_we_", {31'd0, mem_gpr_we_}, 32'd1);
        chk("rst_mem_out", mem_out, 32'd0);
        reset = 1'b0;
        @(posedge clk); #1;

        foreach (vecs[i]) begin
            run_instr(vecs[i].op, vecs[i].out, vecs[i].wr, vecs[i].ec, vecs[i].we_, 5'(i + 1),
                      30'(i + 100), vecs[i].waits, vecs[i].rdata, -1, s, b, fw);
            chk($sformatf("vec%0d_strobes", i), s, vecs[i].e_strobes);
            chk($sformatf("vec%0d_busy", i), b, vecs[i].e_busy);
            chk($sformatf("vec%0d_fwd", i), fw, vecs[i].e_out);
            chk($sformatf("vec%0d_mem_out", i), mem_out, vecs[i].e_out);
            chk($sformatf("vec%0d_we_", i), {31'd0, mem_gpr_we_}, {31'd0, vecs[i].e_we_});
            chk($sformatf("vec%0d_exp", i), {29'd0, mem_exp_code}, {29'd0, vecs[i].e_ec});
            chk($sformatf("vec%0d_en", i), {31'd0, mem_en}, 32'd1);
            chk($sformatf("vec%0d_dst", i), {27'd0, mem_dst_addr}, 32'(i + 1));
            if (vecs[i].e_strobes > 0) begin
                chk($sformatf("vec%0d_addr", i), {2'd0, last_addr}, {2'd0, vecs[i].e_addr});
                chk($sformatf("vec%0d_rw", i), {31'd0, last_rw}, {31'd0, vecs[i].e_rw});
                chk($sformatf("vec%0d_wdata", i), last_wd, vecs[i].wr);
            end
        end

        // Load completing under stall: one strobe, then replay from the buffer.
        ex_en = 1'b1; ex_mem_op = 2'd1; ex_out = 32'h300; ex_exp_code = 3'd0;
        ex_gpr_we_ = 1'b0; ex_dst_addr = 5'd7; bus_rdy_ = 1'b1;
        #1;
        chk("hold_first_strobe", {31'd0, bus_as_}, 32'd0);
        chk("hold_first_busy", {31'd0, busy}, 32'd1);
        @(posedge clk); #1;
        stall = 1'b1; bus_rdy_ = 1'b0; bus_rd_data = 32'hCAFE_F00D;
        #1;
        chk("hold_done_busy", {31'd0, busy}, 32'd0);
        @(posedge clk); #1;
        bus_rdy_ = 1'b1; bus_rd_data = 32'h1111_1111;
        extra = 0;
        for (int c = 0; c < 3; c++) begin
            #1;
            if (bus_as_ === 1'b0) extra++;
            @(posedge clk); #1;
        end
        stall = 1'b0;
        #1;
        if (bus_as_ === 1'b0) extra++;
        chk("hold_fwd", fwd_data, 32'hCAFE_F00D);
        @(posedge clk); #1;
        ex_en = 1'b0; ex_mem_op = 2'd0;
        chk("hold_extra_strobes", extra, 0);
        chk("hold_mem_out", mem_out, 32'hCAFE_F00D);
        chk("hold_we_", {31'd0, mem_gpr_we_}, 32'd0);

        // ALU result then a flush bubble.
        run_instr(2'd0, 32'h55, 32'h0, 3'd0, 1'b0, 5'd3, 30'd9, 0, 32'h0, -1, s, b, fw);
        chk("alu_mem_out", mem_out, 32'h55);
        ex_en = 1'b1; ex_mem_op = 2'd0; ex_out = 32'h77; flush = 1'b1;
        @(posedge clk); #1;
        flush = 1'b0; ex_en = 1'b0;
        chk("flush_en", {31'd0, mem_en}, 32'd0);
        chk("flush_out", mem_out, 32'd0);
        chk("flush_we_", {31'd0, mem_gpr_we_}, 32'd1);

        // Interrupt arriving mid-access: the cycle finishes but the result is dropped.
        run_instr(2'd1, 32'h500, 32'h0, 3'd0, 1'b0, 5'd4, 30'd11, 2, 32'h600D_600D, 1, s, b, fw);
        chk("int_strobes", s, 3);
        chk("int_busy", b, 2);
        chk("int_en", {31'd0, mem_en}, 32'd0);
        chk("int_we_", {31'd0, mem_gpr_we_}, 32'd1);

        for (int n = 0; n < 40; n++) begin
            logic [1:0] op; logic [31:0] out, rd, wr; logic [2:0] ec; logic we_; int w;
            op  = 2'($urandom_range(0, 3));
            out = $urandom;
            if ($urandom_range(0, 3) != 0) out[1:0] = 2'b00;
            ec  = (op != 2'd1 && $urandom_range(0, 3) == 0) ? 3'($urandom_range(1, 7)) : 3'd0;
            we_ = 1'($urandom_range(0, 1));
            w   = $urandom_range(0, 3);
            rd  = $urandom;
            wr  = $urandom;
            e = model(op, out, ec, we_, rd, w);
            run_instr(op, out, wr, ec, we_, 5'(n), 30'(n), w, rd, -1, s, b, fw);
            chk($sformatf("rnd%0d_strobes", n), s, e.strobes);
            chk($sformatf("rnd%0d_out", n), mem_out, e.out);
            chk($sformatf("rnd%0d_we_", n), {31'd0, mem_gpr_we_}, {31'd0, e.we_});
            chk($sformatf("rnd%0d_exp", n), {29'd0, mem_exp_code}, {29'd0, e.ec});
            if (e.strobes > 0)
                chk($sformatf("rnd%0d_addr", n), {2'd0, last_addr}, {2'd0, out[31:2]});
        end

        // Reset during a wait-stated access.
        run_instr(2'd0, 32'h99, 32'h0, 3'd0, 1'b0, 5'd5, 30'd5, 0, 32'h0, -1, s, b, fw);
        chk("pre_rst_out", mem_out, 32'h99);
        ex_en = 1'b1; ex_mem_op = 2'd1; ex_out = 32'h400; ex_exp_code = 3'd0; bus_rdy_ = 1'b1;
        @(posedge clk); #1;
        reset = 1'b1;
        @(posedge clk); #1;
        chk("midrst_bus_as_", {31'd0, bus_as_}, 32'd1);
        chk("midrst_busy", {31'd0, busy}, 32'd0);
        chk("midrst_en", {31'd0, mem_en}, 32'd0);
        chk("midrst_out", mem_out, 32'd0);
        chk("midrst_we_", {31'd0, mem_gpr_we_}, 32'd1);
        chk("midrst_dst", {27'd0, mem_dst_addr}, 32'd0);
        ex_en = 1'b0; ex_mem_op = 2'd0;
        reset = 1'b0;
        @(posedge clk); #1;
        chk("post_rst_bus_as_", {31'd0, bus_as_}, 32'd1);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
